// File: rtl/arith_pkg.sv
// Shared arithmetic unit-test definitions: the FSM state encoding and the
// legal operand-width range for the sequential adder.
package arith_pkg;

  // Operand widths the serial adder can be elaborated with.
  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  // Control states. The encoding is fixed because the fault simulator
  // refers to the state flops by value. 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder cell, built from gate primitives so that its structure
// matches the gate-level subtractor cell.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit       (a ^ b ^ ci)
//   co   : carry out     (majority of a, b, ci)
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  wire p;  // propagate
  wire g;  // generate
  wire t;  // carry propagated through from ci

  xor u_xor_p (p, a, b);
  xor u_xor_s (s, p, ci);
  and u_and_g (g, a, b);
  and u_and_t (t, p, ci);
  or  u_or_co (co, g, t);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: computes {cout, sum} = a + b + cin one bit per clock,
// LSB first, through a single full-adder cell and a carry flop.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (accepted only in IDLE)
//   a, b, cin           : operands and carry-in
//   out_valid/out_ready : result handshake (result held in DONE)
//   sum, cout           : result; intermediate values outside DONE
module serial_adder
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  // Reject unsupported widths at elaboration.
  generate
    if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_width_check
      $error("serial_adder: WIDTH out of supported range");
    end
  endgenerate

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   sa;
  logic [WIDTH-1:0]   sb;
  logic [WIDTH-1:0]   sr;
  logic               cy;
  logic [CNT_W-1:0]   cnt;
  logic               fa_s;
  logic               fa_co;
  logic               last_step;

  // The single full-adder cell works on the current LSBs and the carry.
  full_adder_bit u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (cy),
    .s  (fa_s),
    .co (fa_co)
  );

  // The step taken with cnt == WIDTH-1 produces the MSB.
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = in_valid ? RUN : IDLE;
      RUN:     state_nxt = last_step ? DONE : RUN;
      DONE:    state_nxt = out_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Operand load, serial add step, and hold in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      sr  <= '0;
      cy  <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa  <= a;
            sb  <= b;
            cy  <= cin;
            cnt <= '0;
          end
        end
        RUN: begin
          sr  <= {fa_s, sr[WIDTH-1:1]};
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          cy  <= fa_co;
          cnt <= cnt + CNT_W'(1);
        end
        default: begin
          sa  <= sa;
          sb  <= sb;
          sr  <= sr;
          cy  <= cy;
          cnt <= cnt;
        end
      endcase
    end
  end

  // Result taps the result and carry flops directly.
  assign sum  = sr;
  assign cout = cy;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH = 8): the driver pushes the
// arithmetic expectation of every accepted operand set, the monitor pops and
// compares on each result handshake.
module tb_serial_adder;

  localparam int unsigned W      = 8;
  localparam time         PERIOD = 10;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    time          t0;
  } exp_t;

  exp_t q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  logic prev_valid = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: (W+1)-bit sum of the operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    exp_t e;
    logic [W:0] full;
    full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.t0   = 0;
    return e;
  endfunction

  // Wait for IDLE, present operands, record the expectation at the accepting edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input bit rnd);
    exp_t e;
    int   n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 300) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'(in_ready), 32'd1);
      return;
    end
    a = x; b = y; cin = ci; in_valid = 1'b1;
    @(posedge clk);
    e    = model(x, y, ci);
    e.t0 = $time;
    q.push_back(e);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  // Let every outstanding result drain with the consumer ready.
  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || !in_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  // Monitor: compare the held result every DONE cycle, pop on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_ready && out_valid) check("ready_valid_overlap", 32'd1, 32'd0);
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          // Rising out_valid is seen half a cycle after edge E(W).
          if (!prev_valid)
            check("latency", 32'($time - q[0].t0), 32'(W * PERIOD + PERIOD/2));
          check("sum", 32'(sum), 32'(q[0].sum));
          check("cout", 32'(cout), 32'(q[0].cout));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
    prev_valid = out_valid & rst_n;
  end

  initial begin
    int n;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'h00);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_rst", 32'(in_ready), 32'd1);

    // Basic add, out_valid lasts one cycle
    send(8'h3C, 8'h05, 1'b0, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 50);
    check("basic_valid_seen", 32'(out_valid), 32'd1);
    check("basic_sum_direct", 32'(sum), 32'h41);
    @(negedge clk);
    check("basic_valid_1cycle", 32'(out_valid), 32'd0);
    check("basic_back_idle", 32'(in_ready), 32'd1);

    // Wrap-around and carry-in corners
    send(8'hFF, 8'h01, 1'b0, 1'b0); drain();
    send(8'hFF, 8'hFF, 1'b1, 1'b0); drain();
    send(8'h00, 8'h00, 1'b1, 1'b0); drain();
    send(8'h7F, 8'h00, 1'b1, 1'b0); drain();

    // Backpressure with new operands offered during DONE
    out_ready = 1'b0;
    send(8'h10, 8'h20, 1'b0, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 50);
    check("bp_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = 8'h77; b = 8'h11; cin = 1'b1;
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_sum_stable", 32'(sum), 32'h30);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_in_ready_back", 32'(in_ready), 32'd1);
    check("bp_valid_dropped", 32'(out_valid), 32'd0);
    drain();

    // Reset in the middle of RUN discards the operation
    send(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'h00);
    check("mid_rst_cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(8'h01, 8'h02, 1'b0, 1'b0);
    drain();

    // Random operands with a randomly stalling consumer
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      send(ra, rb, 1'($urandom), 1'b1);
    end
    drain();
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
